uart_rx_frame_timer: RTL and testbench

//   Oversampling timing engine for the UART receiver, generalised from the fixed edge/bit counter.

---
 rtl/uart_rx_frame_timer.sv | 70 +++++++
 tb/tb_uart_rx_frame_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer: oversampling edge/bit counter emitting majority-sample, bit-end and frame-done strobes
module uart_rx_frame_timer #(
  parameter int PRESC_W = 6,
  parameter int BIT_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [BIT_W-1:0]   frame_len,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               busy,
  output logic               sample_tick,
  output logic               vote_tick,
  output logic               bit_tick,
  output logic               frame_done
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t state, state_nx;
  logic [PRESC_W-1:0] p_q, p_nx, edge_nx, mid;
  logic [BIT_W-1:0] l_q, l_nx, bit_nx;
  logic run;
  always_comb begin
    run = state == COUNT && enable && !clear;
    mid = p_q >> 1;
    sample_tick = run && (edge_cnt == mid - PRESC_W'(1) || edge_cnt == mid || edge_cnt == mid + PRESC_W'(1));
    vote_tick = run && edge_cnt == mid + PRESC_W'(1);
    bit_tick = run && edge_cnt == p_q - PRESC_W'(1);
    frame_done = bit_tick && bit_cnt == l_q - BIT_W'(1);
    state_nx = state;
    edge_nx = edge_cnt;
    bit_nx = bit_cnt;
    p_nx = p_q;
    l_nx = l_q;
    if (clear) begin
      state_nx = IDLE;
      edge_nx = '0;
      bit_nx = '0;
    end else if (state == IDLE && enable) begin
      state_nx = COUNT;
      edge_nx = '0;
      bit_nx = '0;
      p_nx = Prescale < PRESC_W'(4) ? PRESC_W'(4) : Prescale;
      l_nx = frame_len < BIT_W'(2) ? BIT_W'(2) : frame_len;
    end else if (run) begin
      edge_nx = bit_tick ? '0 : edge_cnt + PRESC_W'(1);
      bit_nx = frame_done ? '0 : bit_tick ? bit_cnt + BIT_W'(1) : bit_cnt;
      state_nx = frame_done ? IDLE : COUNT;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      edge_cnt <= '0;
      bit_cnt <= '0;
      p_q <= '0;
      l_q <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      edge_cnt <= edge_nx;
      bit_cnt <= bit_nx;
      p_q <= p_nx;
      l_q <= l_nx;
      busy <= state_nx == COUNT;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// tb_uart_rx_frame_timer: random and directed stimulus checked against a frame-position reference model
module tb_uart_rx_frame_timer;
  localparam int PW = 6;
  localparam int BW = 4;
  logic CLK = 0;
  logic RST = 0;
  logic enable = 0;
  logic clear = 0;
  logic [PW-1:0] Prescale = 8;
  logic [BW-1:0] frame_len = 10;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic busy, sample_tick, vote_tick, bit_tick, frame_done;
  int c_pass = 0, c_tot = 0, l_pass = 0, l_tot = 0;
  int cyc = 0;
  uart_rx_frame_timer #(.PRESC_W(PW), .BIT_W(BW)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .clear(clear), .Prescale(Prescale),
    .frame_len(frame_len), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .busy(busy),
    .sample_tick(sample_tick), .vote_tick(vote_tick), .bit_tick(bit_tick), .frame_done(frame_done)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  bit m_act = 0;
  int m_k = 0, m_p = 4, m_l = 2;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_act <= 0;
      m_k <= 0;
    end else if (clear) begin
      m_act <= 0;
      m_k <= 0;
    end else if (!m_act && enable) begin
      m_act <= 1;
      m_k <= 0;
      m_p <= Prescale < 4 ? 4 : int'(Prescale);
      m_l <= frame_len < 2 ? 2 : int'(frame_len);
    end else if (m_act && enable) begin
      if (m_k + 1 == m_p * m_l) begin
        m_act <= 0;
        m_k <= 0;
      end else
        m_k <= m_k + 1;
    end
  end
  bit m_run;
  int m_e, m_b, m_mid;
  always_comb begin
    m_run = m_act && enable && !clear;
    m_e = m_act ? m_k % m_p : 0;
    m_b = m_act ? m_k / m_p : 0;
    m_mid = m_p / 2;
  end
  task automatic chk_c(string n, int act, int exp);
    c_tot++;
    if (act == exp) c_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", n, cyc, act, exp);
  endtask
  task automatic lit(string n, longint act, longint exp);
    l_tot++;
    if (act == exp) l_pass++;
    else $display("FAIL %s got=%0d want=%0d", n, act, exp);
  endtask
  logic busy_q = 0;
  logic [63:0] mask = '0;
  int t_start = 0, vote_edge = -1, bt_period = 0, bt_last = 0, fd_cnt = 0, last_fd = 0;
  always @(negedge CLK) begin
    chk_c("edge_cnt", int'(edge_cnt), m_e);
    chk_c("bit_cnt", int'(bit_cnt), m_b);
    chk_c("busy", int'(busy), int'(m_act));
    chk_c("sample_tick", int'(sample_tick), int'(m_run && m_e >= m_mid - 1 && m_e <= m_mid + 1));
    chk_c("vote_tick", int'(vote_tick), int'(m_run && m_e == m_mid + 1));
    chk_c("bit_tick", int'(bit_tick), int'(m_run && m_e == m_p - 1));
    chk_c("frame_done", int'(frame_done), int'(m_run && m_k == m_p * m_l - 1));
    busy_q <= busy;
    if (busy && !busy_q) begin
      t_start <= cyc;
      mask <= '0;
    end else if (sample_tick && bit_cnt == 0)
      mask <= mask | (64'd1 << edge_cnt);
    if (vote_tick) vote_edge <= int'(edge_cnt);
    if (bit_tick) begin
      bt_period <= cyc - bt_last;
      bt_last <= cyc;
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      last_fd <= cyc;
    end
  end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_idle(int budget);
    int i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    if (busy) begin
      l_tot++;
      $display("FAIL wait_idle timeout after %0d cycles", budget);
    end
    enable = 0;
  endtask
  task automatic start(int p, int l);
    Prescale = PW'(p);
    frame_len = BW'(l);
    enable = 1;
    step();
  endtask
  initial begin
    int fd0, i;
    repeat (2) step();
    RST = 1;
    step();
    lit("reset_busy", busy, 0);
    lit("reset_edge", edge_cnt, 0);
    fd0 = fd_cnt;
    start(8, 10);
    lit("start_busy", busy, 1);
    wait_idle(200);
    lit("p8_span", last_fd - t_start + 1, 80);
    lit("p8_fd_count", fd_cnt - fd0, 1);
    lit("p8_samples", mask, 64'h38);
    lit("p8_vote", vote_edge, 5);
    lit("p8_bit_period", bt_period, 8);
    step();
    lit("no_restart", busy, 0);
    start(8, 10);
    i = 0;
    while (!(bit_cnt == 2 && edge_cnt == 4) && i < 100) begin
      step();
      i++;
    end
    enable = 0;
    repeat (5) begin
      step();
      lit("hold_edge", edge_cnt, 4);
      lit("hold_tick", sample_tick | bit_tick, 0);
    end
    enable = 1;
    wait_idle(200);
    lit("pause_span", last_fd - t_start + 1, 85);
    fd0 = fd_cnt;
    start(8, 10);
    i = 0;
    while (bit_cnt != 6 && i < 100) begin
      step();
      i++;
    end
    clear = 1;
    step();
    clear = 0;
    lit("clear_busy", busy, 0);
    lit("clear_bit", bit_cnt, 0);
    step();
    lit("restart_busy", busy, 1);
    lit("restart_bit", bit_cnt, 0);
    wait_idle(200);
    lit("clear_fd_count", fd_cnt - fd0, 1);
    lit("restart_span", last_fd - t_start + 1, 80);
    start(8, 10);
    repeat (20) step();
    Prescale = 16;
    wait_idle(300);
    lit("latch_span", last_fd - t_start + 1, 80);
    start(2, 3);
    wait_idle(100);
    lit("clamp_span", last_fd - t_start + 1, 12);
    lit("clamp_samples", mask, 64'hE);
    lit("clamp_bit_period", bt_period, 4);
    start(63, 15);
    wait_idle(1200);
    lit("p63_span", last_fd - t_start + 1, 945);
    lit("p63_vote", vote_edge, 32);
    lit("p63_samples", mask, 64'h1_C000_0000);
    lit("p63_bit_period", bt_period, 63);
    start(8, 10);
    repeat (30) step();
    #2 RST = 0;
    #1;
    lit("async_busy", busy, 0);
    lit("async_edge", edge_cnt, 0);
    lit("async_bit", bit_cnt, 0);
    enable = 0;
    step();
    #2 RST = 1;
    step();
    lit("post_reset_busy", busy, 0);
    repeat (4000) begin
      enable = $urandom_range(0, 99) < 85;
      clear = $urandom_range(0, 999) < 3;
      if ($urandom_range(0, 7) == 0) Prescale = PW'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) frame_len = BW'($urandom_range(0, 15));
      step();
    end
    enable = 0;
    clear = 0;
    repeat (2) step();
    $display("%0d/%0d checks passed", c_pass + l_pass, c_tot + l_tot);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
